// File: rtl/snake_ctrl.sv
// snake_ctrl: snake game core on a 40x30 grid of 16x16 px cells.
// Tracks the body segments, steers the head from direction pulses, detects
// wall/body collisions and apple eating, and classifies the pixel being
// scanned (empty/head/body/wall) with one cycle of latency.
// state_dbg mirrors the internal game state for observation only.
module snake_ctrl #(
    parameter int MOVE_DIV = 12_500_000,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 4
) (
    input  logic       CLK_50M,
    input  logic       RSTn,
    input  logic       start,
    input  logic       dir_up,
    input  logic       dir_down,
    input  logic       dir_left,
    input  logic       dir_right,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [5:0] apple_x,
    input  logic [4:0] apple_y,
    output logic [1:0] snake,
    output logic       eat,
    output logic       game_over,
    output logic [4:0] length,
    output logic [1:0] state_dbg
);

    localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_DIV - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_DIE  = 2'd2;

    // Opposite directions differ only in bit 0.
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [4:0] LEN_INIT = 5'(INIT_LEN);
    localparam logic [4:0] LEN_MAX  = 5'(MAX_LEN);

    logic [1:0]       state;
    logic [CNT_W-1:0] step_cnt;
    logic [1:0]       cur_dir;
    logic [1:0]       pend_dir;
    logic [5:0]       seg_x [MAX_LEN];
    logic [4:0]       seg_y [MAX_LEN];
    logic [4:0]       len_q;

    logic       step;
    logic       do_init;
    logic [5:0] next_x;
    logic [4:0] next_y;
    logic       apple_hit;
    logic       wall_hit;
    logic       body_hit;
    logic       collision;
    logic       pulse_any;
    logic [1:0] pulse_dir;
    logic [1:0] eff_dir;
    logic       dir_accept;
    logic [5:0] cell_x;
    logic [4:0] cell_y;
    logic       in_view;
    logic       head_here;
    logic       body_here;
    logic       wall_here;
    logic [1:0] kind;

    assign step      = (state == ST_PLAY) && (step_cnt == CNT_LAST);
    assign do_init   = (state == ST_DIE) && start;
    assign game_over = (state == ST_DIE);
    assign length    = len_q;
    assign state_dbg = state;

    // Head position one cell ahead in the direction that takes effect this step.
    always_comb begin
        next_x = seg_x[0];
        next_y = seg_y[0];
        case (pend_dir)
            DIR_UP:   next_y = seg_y[0] - 5'd1;
            DIR_DOWN: next_y = seg_y[0] + 5'd1;
            DIR_LEFT: next_x = seg_x[0] - 6'd1;
            default:  next_x = seg_x[0] + 6'd1;
        endcase
    end

    // Collision: wall, or any valid body segment; the tail only counts when
    // eating, because otherwise it moves out of the way in the same step.
    always_comb begin
        apple_hit = (next_x == apple_x) && (next_y == apple_y);
        wall_hit  = (next_x == 6'd0) || (next_x == 6'd39) ||
                    (next_y == 5'd0) || (next_y == 5'd29);
        body_hit  = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((5'(i) < len_q) && ((5'(i) != len_q - 5'd1) || apple_hit) &&
                (seg_x[i] == next_x) && (seg_y[i] == next_y)) begin
                body_hit = 1'b1;
            end
        end
        collision = wall_hit | body_hit;
    end

    // Pick one pulse by priority; reject it if it reverses the direction that
    // will be current after this cycle (a step in this cycle commits pend_dir).
    always_comb begin
        pulse_any = dir_up | dir_down | dir_left | dir_right;
        if (dir_up)        pulse_dir = DIR_UP;
        else if (dir_down) pulse_dir = DIR_DOWN;
        else if (dir_left) pulse_dir = DIR_LEFT;
        else               pulse_dir = DIR_RIGHT;
        eff_dir    = step ? pend_dir : cur_dir;
        dir_accept = (state == ST_PLAY) && pulse_any && (pulse_dir != (eff_dir ^ 2'b01));
    end

    // Game state machine.
    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) state <= ST_PLAY;
                ST_PLAY: if (step && collision) state <= ST_DIE;
                ST_DIE:  if (start) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Step divider: runs only while playing, parked at zero otherwise.
    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            step_cnt <= '0;
        end else if (state != ST_PLAY || step) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + 1'b1;
        end
    end

    // Direction: pulses update the pending direction, steps commit it.
    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            cur_dir  <= DIR_RIGHT;
            pend_dir <= DIR_RIGHT;
        end else if (do_init) begin
            cur_dir  <= DIR_RIGHT;
            pend_dir <= DIR_RIGHT;
        end else begin
            if (step)       cur_dir  <= pend_dir;
            if (dir_accept) pend_dir <= pulse_dir;
        end
    end

    // Segment storage: initial horizontal layout, shifted on each safe step.
    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= 6'(20 - i);
                seg_y[i] <= 5'd15;
            end
        end else if (do_init) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= 6'(20 - i);
                seg_y[i] <= 5'd15;
            end
        end else if (step && !collision) begin
            for (int i = 1; i < MAX_LEN; i++) begin
                seg_x[i] <= seg_x[i-1];
                seg_y[i] <= seg_y[i-1];
            end
            seg_x[0] <= next_x;
            seg_y[0] <= next_y;
        end
    end

    // Length and eat pulse; growing keeps the old tail as the new last segment.
    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            len_q <= LEN_INIT;
            eat   <= 1'b0;
        end else if (do_init) begin
            len_q <= LEN_INIT;
            eat   <= 1'b0;
        end else begin
            eat <= step && !collision && apple_hit;
            if (step && !collision && apple_hit && (len_q < LEN_MAX)) begin
                len_q <= len_q + 5'd1;
            end
        end
    end

    // Classify the scanned pixel: head > body > wall > empty, blank off-screen.
    always_comb begin
        cell_x    = x_pos[9:4];
        cell_y    = y_pos[8:4];
        in_view   = (x_pos < 10'd640) && (y_pos < 10'd480);
        head_here = (seg_x[0] == cell_x) && (seg_y[0] == cell_y);
        body_here = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((5'(i) < len_q) && (seg_x[i] == cell_x) && (seg_y[i] == cell_y)) begin
                body_here = 1'b1;
            end
        end
        wall_here = (cell_x == 6'd0) || (cell_x == 6'd39) ||
                    (cell_y == 5'd0) || (cell_y == 5'd29);
        if (!in_view)       kind = 2'd0;
        else if (head_here) kind = 2'd1;
        else if (body_here) kind = 2'd2;
        else if (wall_here) kind = 2'd3;
        else                kind = 2'd0;
    end

    // Register the pixel classification.
    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            snake <= 2'd0;
        end else begin
            snake <= kind;
        end
    end

endmodule

// File: tb/tb_snake_ctrl.sv
// Testbench for snake_ctrl with MOVE_DIV = 4.
// The reference model keeps the snake as a queue of cells (head first) and
// advances one clock at a time from the game rules.
module tb_snake_ctrl;

    localparam int MOVE_DIV = 4;
    localparam int MAX_LEN  = 16;
    localparam int INIT_LEN = 4;

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_OVER = 2;
    localparam int D_UP = 0, D_DOWN = 1, D_LEFT = 2, D_RIGHT = 3;

    logic       CLK_50M;
    logic       RSTn;
    logic       start;
    logic       dir_up, dir_down, dir_left, dir_right;
    logic [9:0] x_pos, y_pos;
    logic [5:0] apple_x;
    logic [4:0] apple_y;
    logic [1:0] snake;
    logic       eat;
    logic       game_over;
    logic [4:0] length;
    logic [1:0] state_dbg;

    int n_cmp;
    int n_bad;

    // reference model
    int m_state;
    int m_cnt;
    int m_dir;
    int m_pend;
    int m_len;
    int qx[$];
    int qy[$];
    int m_snake;
    bit m_eat;

    snake_ctrl #(
        .MOVE_DIV (MOVE_DIV),
        .MAX_LEN  (MAX_LEN),
        .INIT_LEN (INIT_LEN)
    ) dut (
        .CLK_50M   (CLK_50M),
        .RSTn      (RSTn),
        .start     (start),
        .dir_up    (dir_up),
        .dir_down  (dir_down),
        .dir_left  (dir_left),
        .dir_right (dir_right),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .apple_x   (apple_x),
        .apple_y   (apple_y),
        .snake     (snake),
        .eat       (eat),
        .game_over (game_over),
        .length    (length),
        .state_dbg (state_dbg)
    );

    // clock
    initial CLK_50M = 1'b0;
    always #5 CLK_50M = ~CLK_50M;

    // watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    function automatic int opposite(int d);
        case (d)
            D_UP:    return D_DOWN;
            D_DOWN:  return D_UP;
            D_LEFT:  return D_RIGHT;
            default: return D_LEFT;
        endcase
    endfunction

    function automatic int cell_kind(int px, int py);
        int cx, cy;
        if (px >= 640 || py >= 480) return 0;
        cx = px / 16;
        cy = py / 16;
        if (cx == qx[0] && cy == qy[0]) return 1;
        for (int i = 1; i < qx.size(); i++)
            if (cx == qx[i] && cy == qy[i]) return 2;
        if (cx == 0 || cx == 39 || cy == 0 || cy == 29) return 3;
        return 0;
    endfunction

    task automatic m_init();
        qx.delete();
        qy.delete();
        for (int i = 0; i < INIT_LEN; i++) begin
            qx.push_back(20 - i);
            qy.push_back(15);
        end
        m_len   = INIT_LEN;
        m_dir   = D_RIGHT;
        m_pend  = D_RIGHT;
        m_cnt   = 0;
        m_state = M_IDLE;
    endtask

    // Advance the model by one clock using the inputs presently driven.
    task automatic model_clock();
        int  nx, ny, pick;
        bit  stp, hit, coll;
        m_snake = cell_kind(int'(x_pos), int'(y_pos));
        m_eat   = 1'b0;
        case (m_state)
            M_IDLE: if (start) m_state = M_PLAY;
            M_PLAY: begin
                stp   = (m_cnt == MOVE_DIV - 1);
                m_cnt = stp ? 0 : m_cnt + 1;
                if (stp) begin
                    nx = qx[0];
                    ny = qy[0];
                    case (m_pend)
                        D_UP:    ny = ny - 1;
                        D_DOWN:  ny = ny + 1;
                        D_LEFT:  nx = nx - 1;
                        default: nx = nx + 1;
                    endcase
                    hit  = (nx == int'(apple_x)) && (ny == int'(apple_y));
                    coll = (nx == 0 || nx == 39 || ny == 0 || ny == 29);
                    for (int i = 1; i < qx.size(); i++)
                        if (qx[i] == nx && qy[i] == ny && (i != qx.size() - 1 || hit)) coll = 1'b1;
                    m_dir = m_pend;
                    if (coll) begin
                        m_state = M_OVER;
                    end else begin
                        qx.push_front(nx);
                        qy.push_front(ny);
                        if (hit && m_len < MAX_LEN) m_len++;
                        while (qx.size() > m_len) begin
                            void'(qx.pop_back());
                            void'(qy.pop_back());
                        end
                        m_eat = hit;
                    end
                end
                if (dir_up | dir_down | dir_left | dir_right) begin
                    if (dir_up)        pick = D_UP;
                    else if (dir_down) pick = D_DOWN;
                    else if (dir_left) pick = D_LEFT;
                    else               pick = D_RIGHT;
                    if (pick != opposite(m_dir)) m_pend = pick;
                end
            end
            default: if (start) m_init();
        endcase
    endtask

    // driver tasks
    task automatic cycle();
        model_clock();
        @(posedge CLK_50M);
        #1;
        start     = 1'b0;
        dir_up    = 1'b0;
        dir_down  = 1'b0;
        dir_left  = 1'b0;
        dir_right = 1'b0;
    endtask

    task automatic run(int n);
        repeat (n) cycle();
    endtask

    task automatic set_pix(int cx, int cy);
        x_pos = 10'(cx * 16 + 8);
        y_pos = 10'(cy * 16 + 8);
    endtask

    task automatic set_apple(int ax, int ay);
        apple_x = 6'(ax);
        apple_y = 5'(ay);
    endtask

    task automatic do_reset();
        RSTn      = 1'b0;
        start     = 1'b0;
        dir_up    = 1'b0;
        dir_down  = 1'b0;
        dir_left  = 1'b0;
        dir_right = 1'b0;
        m_init();
        repeat (2) @(posedge CLK_50M);
        #1;
        RSTn = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
    endtask

    // scenarios
    task automatic test_reset();
        set_pix(20, 15);
        repeat (3) @(posedge CLK_50M);
        #1;
        n_cmp++; if (snake !== 2'd0) begin n_bad++; $display("FAIL reset_snake: got %0d want 0", snake); end
        n_cmp++; if (eat !== 1'b0) begin n_bad++; $display("FAIL reset_eat: got %0b want 0", eat); end
        n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL reset_game_over: got %0b want 0", game_over); end
        n_cmp++; if (length !== 5'(INIT_LEN)) begin n_bad++; $display("FAIL reset_length: got %0d want %0d", length, INIT_LEN); end
        m_init();
        RSTn = 1'b1;
        cycle();
        n_cmp++; if (snake !== 2'd1) begin n_bad++; $display("FAIL init_head: got %0d want 1", snake); end
        set_pix(17, 15);
        cycle();
        n_cmp++; if (snake !== 2'd2) begin n_bad++; $display("FAIL init_tail: got %0d want 2", snake); end
    endtask

    task automatic test_basic_steps();
        do_reset();
        set_apple(5, 5);
        do_start();
        run(16);
        x_pos = 10'd384;
        y_pos = 10'd240;
        cycle();
        n_cmp++; if (snake !== 2'd1) begin n_bad++; $display("FAIL step4_head: got %0d want 1", snake); end
        n_cmp++; if (length !== 5'd4) begin n_bad++; $display("FAIL step4_length: got %0d want 4", length); end
        set_pix(21, 15);
        cycle();
        n_cmp++; if (snake !== 2'd2) begin n_bad++; $display("FAIL step4_tail: got %0d want 2", snake); end
        set_pix(20, 15);
        cycle();
        n_cmp++; if (snake !== 2'd0) begin n_bad++; $display("FAIL step4_behind_tail: got %0d want 0", snake); end
    endtask

    task automatic test_dir_priority();
        do_reset();
        do_start();
        run(4);
        dir_up   = 1'b1;
        dir_left = 1'b1;
        cycle();
        run(3);
        set_pix(21, 14);
        cycle();
        n_cmp++; if (snake !== 2'd1) begin n_bad++; $display("FAIL prio_head_up: got %0d want 1", snake); end
        set_pix(21, 15);
        cycle();
        n_cmp++; if (snake !== 2'd2) begin n_bad++; $display("FAIL prio_neck: got %0d want 2", snake); end
        set_pix(22, 15);
        cycle();
        n_cmp++; if (snake !== 2'd0) begin n_bad++; $display("FAIL prio_not_right: got %0d want 0", snake); end
    endtask

    task automatic test_reverse_ignored();
        do_reset();
        do_start();
        run(1);
        dir_left = 1'b1;
        cycle();
        run(6);
        set_pix(22, 15);
        cycle();
        n_cmp++; if (snake !== 2'd1) begin n_bad++; $display("FAIL reverse_head: got %0d want 1", snake); end
        set_pix(19, 15);
        cycle();
        n_cmp++; if (snake !== 2'd2) begin n_bad++; $display("FAIL reverse_tail: got %0d want 2", snake); end
    endtask

    task automatic test_eat();
        do_reset();
        set_apple(21, 15);
        do_start();
        run(3);
        n_cmp++; if (eat !== 1'b0) begin n_bad++; $display("FAIL eat_before_step: got %0b want 0", eat); end
        set_pix(21, 15);
        cycle();
        n_cmp++; if (eat !== 1'b1) begin n_bad++; $display("FAIL eat_pulse: got %0b want 1", eat); end
        n_cmp++; if (length !== 5'd5) begin n_bad++; $display("FAIL eat_length: got %0d want 5", length); end
        cycle();
        n_cmp++; if (eat !== 1'b0) begin n_bad++; $display("FAIL eat_one_cycle: got %0b want 0", eat); end
        n_cmp++; if (snake !== 2'd1) begin n_bad++; $display("FAIL eat_head: got %0d want 1", snake); end
        set_pix(17, 15);
        cycle();
        n_cmp++; if (snake !== 2'd2) begin n_bad++; $display("FAIL eat_tail_kept: got %0d want 2", snake); end
        set_pix(16, 15);
        cycle();
        n_cmp++; if (snake !== 2'd0) begin n_bad++; $display("FAIL eat_no_extra: got %0d want 0", snake); end
        set_apple(5, 5);
    endtask

    task automatic test_wall_die();
        do_reset();
        set_apple(5, 5);
        do_start();
        run(75);
        n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL die_not_yet: got %0b want 0", game_over); end
        set_pix(38, 15);
        cycle();
        n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL die_game_over: got %0b want 1", game_over); end
        n_cmp++; if (eat !== 1'b0) begin n_bad++; $display("FAIL die_eat: got %0b want 0", eat); end
        cycle();
        n_cmp++; if (snake !== 2'd1) begin n_bad++; $display("FAIL die_head_stays: got %0d want 1", snake); end
        dir_up = 1'b1;
        run(8);
        n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL die_holds: got %0b want 1", game_over); end
        n_cmp++; if (snake !== 2'd1) begin n_bad++; $display("FAIL die_frozen: got %0d want 1", snake); end
        do_start();
        n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL restart_idle: got %0b want 0", game_over); end
        n_cmp++; if (length !== 5'(INIT_LEN)) begin n_bad++; $display("FAIL restart_length: got %0d want %0d", length, INIT_LEN); end
        set_pix(20, 15);
        cycle();
        n_cmp++; if (snake !== 2'd1) begin n_bad++; $display("FAIL restart_head: got %0d want 1", snake); end
        set_pix(17, 15);
        cycle();
        n_cmp++; if (snake !== 2'd2) begin n_bad++; $display("FAIL restart_tail: got %0d want 2", snake); end
        set_pix(21, 15);
        run(8);
        n_cmp++; if (snake !== 2'd0) begin n_bad++; $display("FAIL idle_no_move: got %0d want 0", snake); end
    endtask

    task automatic test_pixel();
        x_pos = 10'd0;
        y_pos = 10'd100;
        cycle();
        n_cmp++; if (snake !== 2'd3) begin n_bad++; $display("FAIL pix_left_wall: got %0d want 3", snake); end
        x_pos = 10'd700;
        cycle();
        n_cmp++; if (snake !== 2'd0) begin n_bad++; $display("FAIL pix_off_x: got %0d want 0", snake); end
        x_pos = 10'd639;
        y_pos = 10'd479;
        cycle();
        n_cmp++; if (snake !== 2'd3) begin n_bad++; $display("FAIL pix_corner: got %0d want 3", snake); end
        x_pos = 10'd320;
        y_pos = 10'd480;
        cycle();
        n_cmp++; if (snake !== 2'd0) begin n_bad++; $display("FAIL pix_off_y: got %0d want 0", snake); end
    endtask

    task automatic test_saturate();
        do_reset();
        do_start();
        for (int k = 1; k <= 14; k++) begin
            set_apple(20 + k, 15);
            run(4);
        end
        n_cmp++; if (length !== 5'(MAX_LEN)) begin n_bad++; $display("FAIL sat_length: got %0d want %0d", length, MAX_LEN); end
        set_apple(5, 5);
        set_pix(34, 15);
        cycle();
        n_cmp++; if (snake !== 2'd1) begin n_bad++; $display("FAIL sat_head: got %0d want 1", snake); end
        set_pix(19, 15);
        cycle();
        n_cmp++; if (snake !== 2'd2) begin n_bad++; $display("FAIL sat_tail: got %0d want 2", snake); end
        set_pix(18, 15);
        cycle();
        n_cmp++; if (snake !== 2'd0) begin n_bad++; $display("FAIL sat_tail_dropped: got %0d want 0", snake); end
    endtask

    task automatic test_reset_midstep();
        do_reset();
        set_apple(21, 15);
        do_start();
        set_pix(21, 15);
        run(6);
        #2;
        RSTn = 1'b0;
        #1;
        n_cmp++; if (snake !== 2'd0) begin n_bad++; $display("FAIL rst_mid_snake: got %0d want 0", snake); end
        n_cmp++; if (length !== 5'(INIT_LEN)) begin n_bad++; $display("FAIL rst_mid_length: got %0d want %0d", length, INIT_LEN); end
        n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL rst_mid_game_over: got %0b want 0", game_over); end
        m_init();
        @(posedge CLK_50M);
        #1;
        RSTn = 1'b1;
        set_apple(5, 5);
        cycle();
        n_cmp++; if (snake !== 2'd0) begin n_bad++; $display("FAIL rst_no_partial: got %0d want 0", snake); end
        set_pix(20, 15);
        cycle();
        n_cmp++; if (snake !== 2'd1) begin n_bad++; $display("FAIL rst_head_home: got %0d want 1", snake); end
    endtask

    task automatic test_random();
        int ax, ay, idx;
        do_reset();
        set_apple(5, 5);
        for (int c = 0; c < 4000; c++) begin
            start     = ($urandom_range(0, 29) == 0);
            dir_up    = ($urandom_range(0, 7) == 0);
            dir_down  = ($urandom_range(0, 7) == 0);
            dir_left  = ($urandom_range(0, 7) == 0);
            dir_right = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 11) == 0) begin
                ax = qx[0] + int'($urandom_range(0, 4)) - 2;
                ay = qy[0] + int'($urandom_range(0, 4)) - 2;
                if (ax < 1) ax = 1;
                if (ax > 38) ax = 38;
                if (ay < 1) ay = 1;
                if (ay > 28) ay = 28;
                set_apple(ax, ay);
            end
            if ($urandom_range(0, 2) == 0) begin
                idx = int'($urandom_range(0, qx.size() - 1));
                set_pix(qx[idx], qy[idx]);
            end else begin
                x_pos = 10'($urandom_range(0, 799));
                y_pos = 10'($urandom_range(0, 599));
            end
            cycle();
            n_cmp++; if (snake !== 2'(m_snake)) begin n_bad++; $display("FAIL rand_snake c=%0d: got %0d want %0d", c, snake, m_snake); end
            n_cmp++; if (eat !== m_eat) begin n_bad++; $display("FAIL rand_eat c=%0d: got %0b want %0b", c, eat, m_eat); end
            n_cmp++; if (game_over !== (m_state == M_OVER)) begin n_bad++; $display("FAIL rand_game_over c=%0d: got %0b want %0b", c, game_over, m_state == M_OVER); end
            n_cmp++; if (length !== 5'(m_len)) begin n_bad++; $display("FAIL rand_length c=%0d: got %0d want %0d", c, length, m_len); end
        end
    endtask

    // sequence and final report
    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        RSTn      = 1'b0;
        start     = 1'b0;
        dir_up    = 1'b0;
        dir_down  = 1'b0;
        dir_left  = 1'b0;
        dir_right = 1'b0;
        x_pos     = 10'd0;
        y_pos     = 10'd0;
        set_apple(5, 5);
        m_init();
        m_snake = 0;
        m_eat   = 1'b0;

        test_reset();
        test_basic_steps();
        test_dir_priority();
        test_reverse_ignored();
        test_eat();
        test_wall_die();
        test_pixel();
        test_saturate();
        test_reset_midstep();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
